universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised successor to the single-bit enabled D flip-flop: a WIDTH-bit register
//  with clock enable, complementary outputs and eight operating modes.
//  Modes: hold, parallel load, logical/arithmetic shifts, rotates and synchronous clear.
//  Tracks shifts since the last load for serialiser/deserialiser and LFSR-style users.
// PARAMETERS
//  WIDTH      8     register width in bits (>=2)
//  RESET_VAL  0     value of q loaded on async reset (WIDTH bits)
//  CNT_W      4     width of shift counter; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-low
//  enable     in   1        clock enable; 0 = hold everything (incl. counter)
//  mode       in   3        operation select (see BEHAVIOUR)
//  d          in   WIDTH    parallel load data
//  sin_l      in   1        serial in for shift-left (enters bit 0)
//  sin_r      in   1        serial in for shift-right (enters bit WIDTH-1)
//  q          out  WIDTH    register contents
//  qbar       out  WIDTH    ~q, always exact complement
//  sout_l     out  1        q[WIDTH-1] (combinational from q)
//  sout_r     out  1        q[0] (combinational from q)
//  shift_cnt  out  CNT_W    shifts/rotates since last load/clear/reset, saturating
//  zero       out  1        1 when q == 0 (combinational from q)
// BEHAVIOUR
//  Reset:
//   - rst=0 asynchronously forces q=RESET_VAL, qbar=~RESET_VAL, shift_cnt=0
//     regardless of clk/enable; held while rst=0.
//   - First capture occurs on the first rising clk edge after rst deasserts.
//  Enable:
//   - All updates occur on rising clk edge only when rst=1 and enable=1; latency 1 cycle.
//   - enable=0: q and shift_cnt hold regardless of mode.
//  Modes (on enabled edge):
//   000 HOLD  q unchanged, cnt unchanged
//   001 LOAD  q<=d, cnt<=0
//   010 SHL   q<={q[W-2:0],sin_l}, cnt++
//   011 SHR   q<={sin_r,q[W-1:1]}, cnt++
//   100 ROL   q<={q[W-2:0],q[W-1]}, cnt++
//   101 ROR   q<={q[0],q[W-1:1]}, cnt++
//   110 ASR   q<={q[W-1],q[W-1:1]}, cnt++
//   111 CLR   q<=0, cnt<=0 (synchronous; not RESET_VAL)
//  Counter and outputs:
//   - cnt++ saturates at all-ones; no wrap.
//   - Shift/rotate of 0 still counts.
//   - qbar, sout_l, sout_r and zero are derived from registered q; no extra cycle of latency.
//  Boundaries:
//   - rst asserted mid-shift sequence aborts it; the counter returns to 0.
//   - mode changes take effect on the very next enabled edge; no pipeline between modes.
//   - Unknown/X mode is not legal; the design holds q in default branch.
// TESTING (WIDTH=8, RESET_VAL=8'hA5, CNT_W=4)
//  1 rst=0 at t=1, clk running -> q=A5, qbar=5A, cnt=0 immediately;
//    stays while rst=0 even with enable=1, mode=LOAD.
//  2 enable=1, LOAD d=8'h81 -> q=81; SHL sin_l=1 -> 03; SHR sin_r=0 -> 01; cnt=2;
//    sout_r=1.
//  3 q=81: ROL -> 03, ROR -> 81, ASR -> C0, ASR -> E0; cnt=4; qbar=1F.
//  4 enable=0 with mode=SHL for 3 edges -> q and cnt unchanged;
//    enable=1 same edge as mode change applies new mode.
//  5 20 consecutive SHL edges -> cnt saturates at 15; CLR -> q=00, zero=1, cnt=0.
//  6 rst pulse low between edges mid-shift sequence -> q=A5, cnt=0 without a clk edge;
//    next enabled LOAD proceeds normally.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: WIDTH-bit register with clock enable, parallel load,
// logical/arithmetic shifts, rotates, synchronous clear and a saturating count of
// shifts since the last load/clear/reset. Complement, serial-out and zero flags
// are taken straight from the registered value, so they add no latency.
module universal_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,        // asynchronous, active-low
    input  logic             enable_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qbar_o,
    output logic             sout_l_o,
    output logic             sout_r_o,
    output logic [CNT_W-1:0] shift_cnt_o,
    output logic             zero_o
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_sat;

    // Counter increments but sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    // Next-state selection; anything not enabled or not a legal mode holds.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (enable_i) begin
            case (mode_i)
                M_HOLD: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
                M_LOAD: begin
                    q_d   = d_i;
                    cnt_d = '0;
                end
                M_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], sin_l_i};
                    cnt_d = cnt_sat;
                end
                M_SHR: begin
                    q_d   = {sin_r_i, q_q[WIDTH-1:1]};
                    cnt_d = cnt_sat;
                end
                M_ROL: begin
                    q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    cnt_d = cnt_sat;
                end
                M_ROR: begin
                    q_d   = {q_q[0], q_q[WIDTH-1:1]};
                    cnt_d = cnt_sat;
                end
                M_ASR: begin
                    q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    cnt_d = cnt_sat;
                end
                M_CLR: begin
                    // Clear goes to zero, not to the reset value.
                    q_d   = '0;
                    cnt_d = '0;
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // State registers; reset restores RESET_VAL and zeroes the shift count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_q   <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    // Derived outputs come directly from the registered value.
    always_comb begin
        q_o         = q_q;
        qbar_o      = ~q_q;
        sout_l_o    = q_q[WIDTH-1];
        sout_r_o    = q_q[0];
        shift_cnt_o = cnt_q;
        zero_o      = (q_q == '0);
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8, RESET_VAL=A5, CNT_W=4): directed steps
// followed by random operations, checked against an arithmetic reference model.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic [7:0] q, qbar;
    logic       sout_l, sout_r, zero;
    logic [3:0] cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state as plain integers.
    int mq;
    int mc;

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .d_i(d),
        .sin_l_i(sin_l), .sin_r_i(sin_r), .q_o(q), .qbar_o(qbar),
        .sout_l_o(sout_l), .sout_r_o(sout_r), .shift_cnt_o(cnt), .zero_o(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".q"},      16'(q),      16'(mq));
        chk({tag, ".qbar"},   16'(qbar),   16'(255 - mq));
        chk({tag, ".sout_l"}, 16'(sout_l), 16'(mq >= 128));
        chk({tag, ".sout_r"}, 16'(sout_r), 16'(mq % 2));
        chk({tag, ".zero"},   16'(zero),   16'(mq == 0));
        chk({tag, ".cnt"},    16'(cnt),    16'(mc));
    endtask

    function automatic int bump(input int c);
        return (c < 15) ? c + 1 : 15;
    endfunction

    // Apply one operation to the model, expressed as integer arithmetic.
    task automatic model_op(input bit [2:0] m, input int dv, input int sl, input int sr);
        case (m)
            3'd1: begin mq = dv; mc = 0; end
            3'd2: begin mq = (mq * 2) % 256 + sl;                   mc = bump(mc); end
            3'd3: begin mq = mq / 2 + sr * 128;                     mc = bump(mc); end
            3'd4: begin mq = (mq * 2) % 256 + mq / 128;             mc = bump(mc); end
            3'd5: begin mq = mq / 2 + (mq % 2) * 128;               mc = bump(mc); end
            3'd6: begin mq = mq / 2 + ((mq >= 128) ? 128 : 0);      mc = bump(mc); end
            3'd7: begin mq = 0; mc = 0; end
            default: ;
        endcase
    endtask

    task automatic step(input bit en, input bit [2:0] m, input bit [7:0] dv,
                        input bit sl, input bit sr, input string tag);
        @(negedge clk);
        enable = en; mode = m; d = dv; sin_l = sl; sin_r = sr;
        @(posedge clk);
        if (en) model_op(m, int'(dv), int'(sl), int'(sr));
        #1;
        check_model(tag);
    endtask

    initial begin
        // 1: asynchronous reset without a clock edge, held while low
        #1 rst = 1'b0;
        #1;
        mq = 8'hA5; mc = 0;
        chk("rst.q", 16'(q), 16'hA5);
        chk("rst.qbar", 16'(qbar), 16'h5A);
        chk("rst.cnt", 16'(cnt), 16'h0);
        enable = 1'b1; mode = 3'd1; d = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold.q", 16'(q), 16'hA5);
        check_model("rst_hold");
        @(negedge clk);
        rst = 1'b1;

        // 2: load, shift left/right
        step(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, "t2_load");
        chk("t2_load.const", 16'(q), 16'h81);
        step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, "t2_shl");
        chk("t2_shl.const", 16'(q), 16'h03);
        step(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, "t2_shr");
        chk("t2_shr.const", 16'(q), 16'h01);
        chk("t2_cnt.const", 16'(cnt), 16'd2);
        chk("t2_soutr.const", 16'(sout_r), 16'd1);

        // 3: rotates and arithmetic shifts
        step(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, "t3_load");
        step(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, "t3_rol");
        chk("t3_rol.const", 16'(q), 16'h03);
        step(1'b1, 3'd5, 8'h00, 1'b0, 1'b0, "t3_ror");
        chk("t3_ror.const", 16'(q), 16'h81);
        step(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, "t3_asr1");
        chk("t3_asr1.const", 16'(q), 16'hC0);
        step(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, "t3_asr2");
        chk("t3_asr2.const", 16'(q), 16'hE0);
        chk("t3_cnt.const", 16'(cnt), 16'd4);
        chk("t3_qbar.const", 16'(qbar), 16'h1F);

        // 4: disabled edges hold; re-enable with a new mode applies at once
        for (int i = 0; i < 3; i++) step(1'b0, 3'd2, 8'hFF, 1'b1, 1'b1, "t4_dis");
        chk("t4_dis.const", 16'(q), 16'hE0);
        chk("t4_dis_cnt.const", 16'(cnt), 16'd4);
        step(1'b1, 3'd3, 8'h00, 1'b1, 1'b1, "t4_en_shr");
        chk("t4_en_shr.const", 16'(q), 16'hF0);

        // 5: counter saturation, then synchronous clear
        step(1'b1, 3'd1, 8'h00, 1'b0, 1'b0, "t5_load0");
        for (int i = 0; i < 20; i++) step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, "t5_shl0");
        chk("t5_sat.const", 16'(cnt), 16'd15);
        step(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0, "t5_load");
        step(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, "t5_clr");
        chk("t5_clr.const", 16'(q), 16'h00);
        chk("t5_zero.const", 16'(zero), 16'd1);

        // 6: reset pulse between edges mid-sequence
        step(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, "t6_load");
        step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, "t6_shl1");
        step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, "t6_shl2");
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        mq = 8'hA5; mc = 0;
        chk("t6_rst.q", 16'(q), 16'hA5);
        chk("t6_rst.cnt", 16'(cnt), 16'd0);
        #1 rst = 1'b1;
        step(1'b1, 3'd1, 8'h96, 1'b0, 1'b0, "t6_reload");
        chk("t6_reload.const", 16'(q), 16'h96);

        // Random operations against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)),
                 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
